// File: rtl/fp8_window_accum_pkg.sv
//------------------------------------------------------------------------------
// fp8_pkg : shared widths, FSM encoding and saturation limits for the FP8 window
//           accumulator and its decoder.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package fp8_pkg;
  localparam int FP_E_W   = 3;
  localparam int FP_F_W   = 4;
  localparam int FP_MAG_W = 11;
  localparam int FP_VAL_W = FP_MAG_W + 1;

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_DONE  = 1'b1
  } state_t;

  function automatic longint sat_max(input int acc_w);
    return (longint'(1) <<< (acc_w - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int acc_w);
    return -(longint'(1) <<< (acc_w - 1));
  endfunction
endpackage

`default_nettype wire

// File: rtl/fp8_window_accum_if.sv
//------------------------------------------------------------------------------
// fp8_window_accum_if : code input stream and window-sum output stream.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface fp8_window_accum_if #(
  parameter int ACC_W = 16
);
  import fp8_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic                in_s;
  logic [FP_E_W-1:0]   in_e;
  logic [FP_F_W-1:0]   in_f;
  logic                out_valid;
  logic                out_ready;
  logic [ACC_W-1:0]    out_sum;
  logic                out_sat;

  modport slave (
    input  in_valid, in_s, in_e, in_f, out_ready,
    output in_ready, out_valid, out_sum, out_sat
  );

  modport master (
    output in_valid, in_s, in_e, in_f, out_ready,
    input  in_ready, out_valid, out_sum, out_sat
  );
endinterface

`default_nettype wire

// File: rtl/fp8_window_accum_decode.sv
//------------------------------------------------------------------------------
// fp8_decode : expands an (S, E, F) code into the signed linear value F*2^E.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module fp8_decode
  import fp8_pkg::*;
(
  input  logic                       s_i,
  input  logic [FP_E_W-1:0]          e_i,
  input  logic [FP_F_W-1:0]          f_i,
  output logic signed [FP_VAL_W-1:0] val_o
);

  logic [FP_MAG_W-1:0] w_mag;

  // Negating a zero magnitude yields zero, so S=1/F=0 needs no special case.
  always_comb begin
    w_mag = {{(FP_MAG_W - FP_F_W){1'b0}}, f_i} << e_i;
    val_o = s_i ? -$signed({1'b0, w_mag}) : $signed({1'b0, w_mag});
  end

endmodule

`default_nettype wire

// File: rtl/fp8_window_accum.sv
//------------------------------------------------------------------------------
// fp8_window_accum : sums N_SAMPLES decoded FP8 codes per window and hands the
//                    result out on a valid/ready stream.
// Option macro FP8_ACCUM_SAT_EN: clamp each addition and report it on out_sat.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module fp8_window_accum
  import fp8_pkg::*;
#(
  parameter int N_SAMPLES = 16,
  parameter int ACC_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  fp8_window_accum_if.slave  bus
);

  localparam int c_CNT_W = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;

  state_t                      state_q, state_d;
  logic [c_CNT_W-1:0]          cnt_q;
  logic [ACC_W-1:0]            acc_q;
  logic [ACC_W-1:0]            out_sum_q;
  logic signed [FP_VAL_W-1:0]  w_val;
  logic [ACC_W-1:0]            w_acc_nxt;
  logic                        w_accept;
  logic                        w_last;

  fp8_decode u_decode (
    .s_i   (bus.in_s),
    .e_i   (bus.in_e),
    .f_i   (bus.in_f),
    .val_o (w_val)
  );

  // Accept is derived from the registered state rather than in_ready to keep
  // the FSM output logic free of a combinational loop.
  assign w_accept    = bus.in_valid & (state_q == ST_ACCUM);
  assign w_last      = (cnt_q == c_CNT_W'(N_SAMPLES - 1));
  assign bus.out_sum = out_sum_q;

`ifdef FP8_ACCUM_SAT_EN
  localparam logic [ACC_W-1:0] c_SAT_MAX = ACC_W'(sat_max(ACC_W));
  localparam logic [ACC_W-1:0] c_SAT_MIN = ACC_W'(sat_min(ACC_W));

  logic [ACC_W:0] w_val_ext;
  logic [ACC_W:0] w_sum;
  logic           w_clamp;
  logic           win_sat_q;
  logic           out_sat_q;

  assign w_val_ext = (ACC_W + 1)'(w_val);

  always_comb begin
    w_sum   = {acc_q[ACC_W-1], acc_q} + w_val_ext;
    w_clamp = w_sum[ACC_W] ^ w_sum[ACC_W-1];
    if (!w_clamp) begin
      w_acc_nxt = w_sum[ACC_W-1:0];
    end else if (w_sum[ACC_W]) begin
      w_acc_nxt = c_SAT_MIN;
    end else begin
      w_acc_nxt = c_SAT_MAX;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_sat_q <= 1'b0;
      out_sat_q <= 1'b0;
    end else if (clr) begin
      win_sat_q <= 1'b0;
      out_sat_q <= 1'b0;
    end else if ((state_q == ST_DONE) && bus.out_ready) begin
      out_sat_q <= 1'b0;
    end else if (w_accept) begin
      if (w_last) begin
        out_sat_q <= win_sat_q | w_clamp;
        win_sat_q <= 1'b0;
      end else begin
        win_sat_q <= win_sat_q | w_clamp;
      end
    end
  end

  assign bus.out_sat = out_sat_q;
`else
  logic [ACC_W-1:0] w_val_ext;

  assign w_val_ext   = ACC_W'(w_val);
  assign w_acc_nxt   = acc_q + w_val_ext;
  assign bus.out_sat = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      out_sum_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (w_accept) begin
      if (w_last) begin
        out_sum_q <= w_acc_nxt;
        acc_q     <= '0;
        cnt_q     <= '0;
      end else begin
        acc_q <= w_acc_nxt;
        cnt_q <= cnt_q + c_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      ST_ACCUM: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid && w_last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_d = ST_ACCUM;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
    if (clr) begin
      state_d = ST_ACCUM;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fp8_window_accum.sv
//------------------------------------------------------------------------------
// tb_fp8_window_accum : scoreboard bench for fp8_window_accum (N=16 and N=32).
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_fp8_window_accum;
  import fp8_pkg::*;

  typedef struct packed {
    logic [15:0] sum;
    logic        sat;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clr   = 1'b0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  logic [15:0] last_sum;

  always #5 clk = ~clk;

  fp8_window_accum_if #(.ACC_W(16)) a ();
  fp8_window_accum_if #(.ACC_W(16)) b ();

  fp8_window_accum #(.N_SAMPLES(16), .ACC_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(a.slave)
  );
  fp8_window_accum #(.N_SAMPLES(32), .ACC_W(16)) dut32 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(b.slave)
  );

  function automatic int code_val(input bit s, input int e, input int f);
    int m;
    m = f * (1 << e);
    return s ? -m : m;
  endfunction

  function automatic int model_add(input int acc, input int v, inout bit sat);
    int r;
    r = acc + v;
`ifdef FP8_ACCUM_SAT_EN
    if (r > 32767)  begin r = 32767;  sat = 1'b1; end
    if (r < -32768) begin r = -32768; sat = 1'b1; end
`else
    r = ((r + 32768) & 32'hFFFF) - 32768;
`endif
    return r;
  endfunction

  task automatic send(input bit sel, input bit s, input int e, input int f);
    int t;
    t = 0;
    if (sel) begin b.in_valid = 1'b1; b.in_s = s; b.in_e = 3'(e); b.in_f = 4'(f); end
    else     begin a.in_valid = 1'b1; a.in_s = s; a.in_e = 3'(e); a.in_f = 4'(f); end
    forever begin
      @(negedge clk);
      if (sel ? b.in_ready : a.in_ready) break;
      t++;
      if (t > 200) begin
        checks++; errors++;
        $display("FAIL send_timeout: in_ready=0 after %0d cycles, required 1", t);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_out(input bit sel, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      if (sel ? b.out_valid : a.out_valid) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    exp_t x; bit ok; int m; bit ms;
    a.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(0, 0, 0, 1);
    a.in_valid = 1'b0;
    checks++;
    if (a.out_valid !== 1'b1 || a.out_sum !== 16'd16) begin
      errors++; $display("FAIL pre_reset: valid=%0b sum=%0d, required valid=1 sum=16", a.out_valid, a.out_sum);
    end
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++; if (a.in_ready !== 1'b1)  begin errors++; $display("FAIL rst_in_ready: got %0b required 1", a.in_ready); end
    checks++; if (a.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %0b required 0", a.out_valid); end
    checks++; if (a.out_sum !== 16'd0)  begin errors++; $display("FAIL rst_out_sum: got %0d required 0", a.out_sum); end
    checks++; if (a.out_sat !== 1'b0)   begin errors++; $display("FAIL rst_out_sat: got %0b required 0", a.out_sat); end
    a.in_valid = 1'b1; a.in_s = 1'b0; a.in_e = 3'd0; a.in_f = 4'd1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    a.in_valid = 1'b0; a.out_ready = 1'b1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    m = 0; ms = 1'b0;
    for (int i = 0; i < 16; i++) m = model_add(m, code_val(0, 0, 1), ms);
    sb.push_back({16'(m), ms});
    for (int i = 0; i < 16; i++) send(0, 0, 0, 1);
    a.in_valid = 1'b0;
    wait_out(0, ok); x = sb.pop_front();
    checks++;
    if (!ok || a.out_sum !== x.sum || a.out_sat !== x.sat) begin
      errors++; $display("FAIL reset_window: valid=%0b sum=%0d sat=%0b, required sum=%0d sat=%0b", ok, a.out_sum, a.out_sat, x.sum, x.sat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_unit_window();
    exp_t x; int m; bit ms;
    m = 0; ms = 1'b0;
    for (int i = 0; i < 16; i++) m = model_add(m, code_val(0, 0, 1), ms);
    sb.push_back({16'(m), ms});
    for (int i = 0; i < 16; i++) begin
      send(0, 0, 0, 1);
      if (i == 14) begin
        checks++;
        if (a.out_valid !== 1'b0) begin errors++; $display("FAIL unit_early: out_valid=%0b after 15 accepts, required 0", a.out_valid); end
      end
    end
    a.in_valid = 1'b0;
    checks++;
    if (a.out_valid !== 1'b1 || a.in_ready !== 1'b0) begin
      errors++; $display("FAIL unit_latency: out_valid=%0b in_ready=%0b, required 1/0", a.out_valid, a.in_ready);
    end
    x = sb.pop_front();
    checks++;
    if (a.out_sum !== x.sum || a.out_sat !== x.sat) begin
      errors++; $display("FAIL unit_sum: sum=%0d sat=%0b, required sum=%0d sat=%0b", a.out_sum, a.out_sat, x.sum, x.sat);
    end
    @(posedge clk); #1;
    checks++;
    if (a.out_valid !== 1'b0 || a.in_ready !== 1'b1) begin
      errors++; $display("FAIL unit_release: out_valid=%0b in_ready=%0b, required 0/1", a.out_valid, a.in_ready);
    end
  endtask

  task automatic test_mixed_signs();
    exp_t x; bit ok; int m; bit ms;
    m = 0; ms = 1'b0;
    for (int i = 0; i < 8; i++) m = model_add(m, code_val(0, 3, 10), ms);
    for (int i = 0; i < 8; i++) m = model_add(m, code_val(1, 2, 5), ms);
    sb.push_back({16'(m), ms});
    for (int i = 0; i < 8; i++) send(0, 0, 3, 10);
    for (int i = 0; i < 8; i++) send(0, 1, 2, 5);
    a.in_valid = 1'b0;
    wait_out(0, ok); x = sb.pop_front();
    checks++;
    if (!ok || a.out_sum !== x.sum || a.out_sat !== x.sat || x.sum !== 16'd480) begin
      errors++; $display("FAIL mixed_sum: valid=%0b sum=%0d sat=%0b, required sum=%0d(480) sat=%0b", ok, a.out_sum, a.out_sat, x.sum, x.sat);
    end
    @(posedge clk); #1;
    m = 0; ms = 1'b0;
    m = model_add(m, code_val(1, 5, 0), ms);
    for (int i = 0; i < 15; i++) m = model_add(m, code_val(0, 0, 1), ms);
    sb.push_back({16'(m), ms});
    send(0, 1, 5, 0);
    for (int i = 0; i < 15; i++) send(0, 0, 0, 1);
    a.in_valid = 1'b0;
    wait_out(0, ok); x = sb.pop_front();
    checks++;
    if (!ok || a.out_sum !== x.sum || a.out_sat !== x.sat) begin
      errors++; $display("FAIL neg_zero_sum: valid=%0b sum=%0d sat=%0b, required sum=%0d sat=%0b", ok, a.out_sum, a.out_sat, x.sum, x.sat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    exp_t x; bit ok; int m; bit ms;
    a.out_ready = 1'b0;
    m = 0; ms = 1'b0;
    for (int i = 0; i < 16; i++) m = model_add(m, code_val(0, 1, 3), ms);
    sb.push_back({16'(m), ms});
    for (int i = 0; i < 16; i++) send(0, 0, 1, 3);
    a.in_valid = 1'b1; a.in_s = 1'b0; a.in_e = 3'd4; a.in_f = 4'd15;
    wait_out(0, ok); x = sb.pop_front();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (!ok || a.in_ready !== 1'b0 || a.out_valid !== 1'b1 || a.out_sum !== x.sum) begin
        errors++; $display("FAIL bp_hold[%0d]: in_ready=%0b out_valid=%0b sum=%0d, required 0/1/%0d", k, a.in_ready, a.out_valid, a.out_sum, x.sum);
      end
      @(posedge clk); #1;
    end
    a.out_ready = 1'b1;
    m = 0; ms = 1'b0;
    for (int i = 0; i < 16; i++) m = model_add(m, code_val(0, 4, 15), ms);
    sb.push_back({16'(m), ms});
    last_sum = 16'(m);
    for (int i = 0; i < 16; i++) send(0, 0, 4, 15);
    a.in_valid = 1'b0;
    wait_out(0, ok); x = sb.pop_front();
    checks++;
    if (!ok || a.out_sum !== x.sum || a.out_sat !== x.sat) begin
      errors++; $display("FAIL bp_next: valid=%0b sum=%0d sat=%0b, required sum=%0d sat=%0b", ok, a.out_sum, a.out_sat, x.sum, x.sat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    exp_t x; bit ok; int m; bit ms;
    for (int i = 0; i < 5; i++) send(0, 0, 7, 15);
    a.in_valid = 1'b1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; a.in_valid = 1'b0;
    checks++;
    if (a.out_valid !== 1'b0 || a.out_sum !== last_sum) begin
      errors++; $display("FAIL abort_state: out_valid=%0b sum=%0d, required 0/%0d", a.out_valid, a.out_sum, last_sum);
    end
    m = 0; ms = 1'b0;
    for (int i = 0; i < 16; i++) m = model_add(m, code_val(0, 0, 2), ms);
    sb.push_back({16'(m), ms});
    for (int i = 0; i < 16; i++) send(0, 0, 0, 2);
    a.in_valid = 1'b0;
    wait_out(0, ok); x = sb.pop_front();
    checks++;
    if (!ok || a.out_sum !== x.sum || a.out_sat !== x.sat || x.sum !== 16'd32) begin
      errors++; $display("FAIL abort_sum: valid=%0b sum=%0d sat=%0b, required sum=%0d(32) sat=%0b", ok, a.out_sum, a.out_sat, x.sum, x.sat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    exp_t x; bit ok; int m; bit ms;
    m = 0; ms = 1'b0;
    for (int i = 0; i < 32; i++) m = model_add(m, code_val(0, 7, 15), ms);
    sb.push_back({16'(m), ms});
    for (int i = 0; i < 32; i++) send(1, 0, 7, 15);
    b.in_valid = 1'b0;
    wait_out(1, ok); x = sb.pop_front();
    checks++;
    if (!ok || b.out_sum !== x.sum || b.out_sat !== x.sat) begin
      errors++; $display("FAIL sat_sum: valid=%0b sum=%h sat=%0b, required sum=%h sat=%0b", ok, b.out_sum, b.out_sat, x.sum, x.sat);
    end
    @(posedge clk); #1;
    checks++;
    if (b.out_valid !== 1'b0 || b.out_sat !== 1'b0) begin
      errors++; $display("FAIL sat_clear: out_valid=%0b out_sat=%0b, required 0/0", b.out_valid, b.out_sat);
    end
  endtask

  initial begin
    a.in_valid = 1'b0; a.in_s = 1'b0; a.in_e = '0; a.in_f = '0; a.out_ready = 1'b1;
    b.in_valid = 1'b0; b.in_s = 1'b0; b.in_e = '0; b.in_f = '0; b.out_ready = 1'b1;
    last_sum = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_unit_window();
    test_mixed_signs();
    test_backpressure();
    test_abort();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/fp8_window_accum.md
Name: fp8_window_accum

Overview:
- Downstream consumer of the 12-bit-to-8-bit float converter.
- Accepts its output code (S, E[2:0], F[3:0]) through a valid/ready handshake.
- Expands each code back to a signed linear value, F·2^E.
- Accumulates N_SAMPLES values per window and presents the windowed sum through a second valid/ready handshake, for block-level energy/level measurement.

Parameters:
- N_SAMPLES, 16, number of accepted codes per window (≥2).
- ACC_W, 16, signed accumulator and output width (≥12).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous window abort.
- in_valid  in  1  code present.
- in_ready  out  1  block can accept a code.
- in_s  in  1  sign.
- in_e  in  3  exponent.
- in_f  in  4  significand.
- out_valid  out  1  window sum available.
- out_ready  in  1  consumer takes sum.
- out_sum  out  ACC_W  signed window sum.
- out_sat  out  1  saturation occurred in this window.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values:
  - State is ACCUM; acc, cnt, out_sum and out_sat are 0.
  - out_valid=0, in_ready=1.
- Decode (combinational):
  - mag = F << E, 11 bits unsigned, range 0..1920.
  - val = S ? -mag : mag, sign-extended to ACC_W.
  - S=1 with F=0 decodes to 0.
- FSM has two states, ACCUM and DONE.
- ACCUM:
  - in_ready=1, out_valid=0.
  - Accept occurs when in_valid & in_ready.
  - On each accept: acc ← acc+val and cnt ← cnt+1.
  - On the accept with cnt==N_SAMPLES-1: out_sum ← acc+val, out_sat is updated, acc ← 0, cnt ← 0, state → DONE.
- DONE:
  - in_ready=0, out_valid=1.
  - out_sum and out_sat are held stable while out_ready=0.
  - When out_ready=1: state → ACCUM, out_sat cleared next cycle.
- Latency and throughput:
  - out_valid rises on the cycle after the final accept.
  - Throughput is N_SAMPLES codes per N_SAMPLES+1 cycles minimum, because DONE always costs one bubble.
- in_valid while in_ready=0 is ignored. The producer holds the code; no sample is lost or double-counted.
- clr:
  - Any state goes to ACCUM with acc=0, cnt=0, out_valid=0, out_sat=0.
  - clr has priority over an accept or out_ready in the same cycle.
  - out_sum retains its last value.
- Reset asserted mid-window: immediate return to reset values; the partial window is discarded.
- Arithmetic is ACC_W+1 bits internally; overflow is handled per Optional Feature.
- cnt width is clog2(N_SAMPLES) and it never exceeds N_SAMPLES-1.

Optional Feature:
- Macro: FP8_ACCUM_SAT_EN.
- Defined:
  - Each addition clamps to +(2^(ACC_W-1)-1) or -(2^(ACC_W-1)).
  - Any clamp in the window sets out_sat for that window's result.
- Undefined:
  - Additions wrap modulo 2^ACC_W.
  - out_sat is tied to 0.

Decomposition:
- Package fp8_pkg contains:
  - FP_E_W=3, FP_F_W=4, FP_MAG_W=11.
  - State encoding ST_ACCUM=0, ST_DONE=1.
  - A function or constants for the saturation limits derived from ACC_W.
- One sub-module, fp8_decode: combinational (S, E, F) → signed 12-bit value. It is reusable by other consumers of the converter output.

Test Plan:
- Reset: pulse rst_n low asynchronously, mid-cycle → in_ready=1, out_valid=0, out_sum=0, out_sat=0 immediately; hold rst_n low during 5 accepts, release, feed 16 codes (S0,E0,F1) → out_sum=16.
- Unit window: 16 codes (S0,E0,F1), in_valid held high → out_valid=1 exactly one cycle after 16th accept, out_sum=16, in_ready=0 in that cycle.
- Mixed signs:
  - Stimulus: 8×(S0,E3,F10) and 8×(S1,E2,F5).
  - Value per code: +80 and −20.
  - Expected: out_sum=480; (S1,E5,F0) in a later window contributes 0.
- Backpressure: out_ready=0 for 5 cycles after out_valid with in_valid=1 → in_ready=0, out_sum stable, no accept counted; next window still sums exactly 16 codes.
- Abort: clr after 5 accepts of (S0,E7,F15), same cycle as a 6th in_valid → that code not counted; following 16×(S0,E0,F2) gives out_sum=32.
- Saturation, N_SAMPLES=32, 32×(S0,E7,F15) giving a true sum of 61440:
  - With FP8_ACCUM_SAT_EN: out_sum=32767, out_sat=1.
  - Without: out_sum=16'hF000 (−4096), out_sat=0.
